// File: rtl/multi_range_tracker.sv
// multi_range_tracker: per-channel min/max over a go..finish window, reports max-min and a saturating sample count.
// Define RANGE_SIGNED_EN to treat samples as two's complement (signed compare, unsigned magnitude range).
module multi_range_tracker #(
    parameter int WIDTH   = 12,
    parameter int NUM_CH  = 2,
    parameter int COUNT_W = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      go,
    input  logic                      finish,
    input  logic [NUM_CH*WIDTH-1:0]   data_in,
    output logic [NUM_CH*WIDTH-1:0]   range_out,
    output logic                      range_valid,
    output logic                      busy,
    output logic                      error,
    output logic [COUNT_W-1:0]        sample_count
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2;
    logic [1:0] state;
    logic [NUM_CH*WIDTH-1:0] mn, mx, nmn, nmx, rng;
    logic [COUNT_W-1:0] cnt, ncnt;

    function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef RANGE_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [WIDTH-1:0] d, lo, hi;
            logic [WIDTH:0] diff;
            assign d    = data_in[c*WIDTH +: WIDTH];
            assign lo   = less(d, mn[c*WIDTH +: WIDTH]) ? d : mn[c*WIDTH +: WIDTH];
            assign hi   = less(mx[c*WIDTH +: WIDTH], d) ? d : mx[c*WIDTH +: WIDTH];
            assign diff = {1'b0, hi} - {1'b0, lo};
            assign nmn[c*WIDTH +: WIDTH] = lo;
            assign nmx[c*WIDTH +: WIDTH] = hi;
            assign rng[c*WIDTH +: WIDTH] = diff[WIDTH-1:0];
        end
    endgenerate

    assign ncnt = (&cnt) ? cnt : cnt + 1'b1;
    assign busy = (state == RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            mn           <= '0;
            mx           <= '0;
            cnt          <= '0;
            range_out    <= '0;
            range_valid  <= 1'b0;
            error        <= 1'b0;
            sample_count <= '0;
        end else begin
            range_valid <= 1'b0;
            if (state != RUN) begin
                if (finish) begin
                    state <= ERR;
                    error <= 1'b1;
                end else if (go) begin
                    state <= RUN;
                    mn    <= data_in;
                    mx    <= data_in;
                    cnt   <= {{(COUNT_W-1){1'b0}}, 1'b1};
                    error <= 1'b0;
                end
            end else if (finish) begin
                if (go) begin
                    state <= ERR;
                    error <= 1'b1;
                end else begin
                    state        <= IDLE;
                    range_out    <= rng;
                    sample_count <= ncnt;
                    range_valid  <= 1'b1;
                end
            end else begin
                mn  <= nmn;
                mx  <= nmx;
                cnt <= ncnt;
            end
        end
    end
endmodule

// File: tb/tb_multi_range_tracker.sv
// tb_multi_range_tracker: random and directed stimulus against a queue-based window model.
module tb_multi_range_tracker;
    logic        clock = 0, reset_n = 0, go = 0, finish = 0;
    logic [23:0] data_in = '0;
    logic [23:0] range_out;
    logic        range_valid, busy, error;
    logic [7:0]  sample_count;
    int nvec = 0, nbad = 0;

    logic [23:0] win[$];
    int          ms = 0;
    logic [23:0] e_rng = '0;
    logic [7:0]  e_cnt = '0;
    logic        e_valid = 0, e_err = 0;

    multi_range_tracker #(.WIDTH(12), .NUM_CH(2), .COUNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .go(go), .finish(finish), .data_in(data_in),
        .range_out(range_out), .range_valid(range_valid), .busy(busy), .error(error),
        .sample_count(sample_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sval(input logic [11:0] v);
`ifdef RANGE_SIGNED_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    function automatic void close_window();
        for (int ch = 0; ch < 2; ch++) begin
            int lo, hi, v;
            lo = sval(win[0][ch*12 +: 12]);
            hi = lo;
            foreach (win[i]) begin
                v = sval(win[i][ch*12 +: 12]);
                if (v < lo) lo = v;
                if (v > hi) hi = v;
            end
            e_rng[ch*12 +: 12] = 12'(hi - lo);
        end
        e_cnt = win.size() > 255 ? 8'd255 : 8'(win.size());
    endfunction

    task automatic check_all();
        check("range_out", range_out, e_rng);
        check("range_valid", range_valid, e_valid);
        check("busy", busy, ms == 1);
        check("error", error, e_err);
        check("sample_count", sample_count, e_cnt);
    endtask

    task automatic step(input logic g, input logic f, input logic [23:0] d);
        go = g; finish = f; data_in = d;
        @(posedge clock);
        e_valid = 0;
        if (ms != 1) begin
            if (f) begin ms = 2; e_err = 1; end
            else if (g) begin ms = 1; e_err = 0; win.delete(); win.push_back(d); end
        end else if (f && g) begin
            ms = 2; e_err = 1;
        end else begin
            win.push_back(d);
            if (f) begin close_window(); ms = 0; e_valid = 1; end
        end
        #1 check_all();
    endtask

    function automatic logic [11:0] rsamp();
        logic [11:0] pick[4] = '{12'h000, 12'hFFF, 12'h800, 12'h7FF};
        return $urandom_range(0, 3) == 0 ? pick[$urandom_range(0, 3)] : 12'($urandom);
    endfunction

    initial begin
        #1 check_all();
        #6 reset_n = 1;
        // 1: basic window, ch1 constant
        step(1, 0, {12'd100, 12'd5});
        step(0, 0, {12'd100, 12'd9});
        step(0, 0, {12'd100, 12'd2});
        step(0, 1, {12'd100, 12'd7});
        check("t1_ch0", range_out[11:0], 7);
        check("t1_ch1", range_out[23:12], 0);
        check("t1_cnt", sample_count, 4);
        step(0, 0, 24'd0);
        // 2: finish in IDLE, then restart with minimum window
        step(0, 1, 24'd50);
        check("t2_err", error, 1);
        step(1, 0, {12'd0, 12'd10});
        check("t2_errclr", error, 0);
        step(0, 1, {12'd0, 12'd3});
        check("t2_ch0", range_out[11:0], 7);
        check("t2_cnt", sample_count, 2);
        // 3: go+finish in IDLE and in RUN
        step(1, 1, 24'h123456);
        step(1, 0, 24'h111111);
        step(1, 1, 24'h222222);
        check("t3_keep", range_out[11:0], 7);
        // 4: saturated count
        step(1, 0, {12'd40, 12'd1000});
        for (int i = 0; i < 298; i++) step(0, 0, {12'(40 + i % 7), 12'(1000 + i % 13)});
        step(0, 1, {12'd40, 12'd1000});
        check("t4_cnt", sample_count, 255);
        check("t4_ch0", range_out[11:0], 12);
        // 5: async reset mid-window
        step(1, 0, 24'hABCDEF);
        step(0, 0, 24'h012345);
        #3 reset_n = 0;
        #1;
        ms = 0; e_rng = '0; e_cnt = '0; e_valid = 0; e_err = 0;
        check_all();
        #2 reset_n = 1;
        step(0, 1, 24'd0);
        check("t5_err", error, 1);
        // 6: signed/unsigned magnitude
        step(1, 0, {12'd0, 12'hFFF});
        step(0, 0, {12'd0, 12'h005});
        step(0, 1, {12'd0, 12'h800});
`ifdef RANGE_SIGNED_EN
        check("t6_ch0", range_out[11:0], 2053);
`else
        check("t6_ch0", range_out[11:0], 4090);
`endif
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic g, f;
            g = ($urandom_range(0, 7) == 0);
            f = ($urandom_range(0, 9) == 0);
            step(g, f, {rsamp(), rsamp()});
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
